// File: rtl/baud_tick_gen.sv
// Programmable baud-rate tick generator.
// A period counter divides clk_in by a runtime-loadable divisor N to produce os_tick.
// An oversample counter divides os_tick by OVS to produce the bit-centre pulse (mid_tick),
// the bit-boundary pulse (bit_tick) and a 50% duty square wave (clk_div).
// Divisor writes are staged in a pending register. They only take effect at a safe point:
// a period wrap, a phase resync, or any cycle with enable low.
module baud_tick_gen #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned OVS       = 16,
  parameter int unsigned DIV_RESET = 325
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             resync,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_in,
  output logic [CNT_W-1:0] div_active,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic             clk_div
);

  localparam int unsigned      OcntW       = $clog2(OVS);
  localparam logic [OcntW-1:0] OcntLast    = OcntW'(OVS - 1);
  // The wrap taken from this value lands on the bit centre (OVS/2).
  localparam logic [OcntW-1:0] OcntMidPrev = OcntW'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] DivReset    = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [OcntW-1:0] ocnt_q, ocnt_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             os_tick_q, os_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             clk_div_q, clk_div_d;

  logic [CNT_W-1:0] term_cnt;
  logic             wrap;
  logic             apply_pend;

  // Terminal count of the period counter. A divisor of 0 behaves as 1.
  always_comb begin
    term_cnt = '0;
    if (div_active_q != '0) begin
      term_cnt = div_active_q - CNT_W'(1);
    end
  end

  // Wrap detection and the divisor-transfer window.
  // The >= comparison stops pcnt from running away after a smaller divisor is applied while
  // pcnt is held above the new terminal count.
  always_comb begin
    wrap       = enable & ~resync & (pcnt_q >= term_cnt);
    apply_pend = resync | wrap | ~enable;
  end

  // Period and oversample counters, tick generation and the square wave.
  always_comb begin
    pcnt_d     = pcnt_q;
    ocnt_d     = ocnt_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    clk_div_d  = clk_div_q;

    if (resync) begin
      pcnt_d    = '0;
      ocnt_d    = '0;
      clk_div_d = 1'b0;
    end else if (enable) begin
      if (wrap) begin
        pcnt_d    = '0;
        os_tick_d = 1'b1;
        if (ocnt_q == OcntLast) begin
          ocnt_d     = '0;
          bit_tick_d = 1'b1;
          clk_div_d  = 1'b0;
        end else begin
          ocnt_d = ocnt_q + OcntW'(1);
        end
        if (ocnt_q == OcntMidPrev) begin
          mid_tick_d = 1'b1;
          clk_div_d  = 1'b1;
        end
      end else begin
        pcnt_d = pcnt_q + CNT_W'(1);
      end
    end
  end

  // Divisor staging.
  // The pending value is applied first. A write in the same cycle then re-arms pending with the
  // new value, so it waits for the next transfer window.
  always_comb begin
    div_active_d = div_active_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;

    if (apply_pend && pend_valid_q) begin
      div_active_d = pend_div_q;
      pend_valid_d = 1'b0;
    end
    if (div_wr) begin
      pend_div_d   = div_in;
      pend_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pcnt_q       <= '0;
      ocnt_q       <= '0;
      div_active_q <= DivReset;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      os_tick_q    <= 1'b0;
      mid_tick_q   <= 1'b0;
      bit_tick_q   <= 1'b0;
      clk_div_q    <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      ocnt_q       <= ocnt_d;
      div_active_q <= div_active_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      os_tick_q    <= os_tick_d;
      mid_tick_q   <= mid_tick_d;
      bit_tick_q   <= bit_tick_d;
      clk_div_q    <= clk_div_d;
    end
  end

  assign div_active = div_active_q;
  assign os_tick    = os_tick_q;
  assign mid_tick   = mid_tick_q;
  assign bit_tick   = bit_tick_q;
  assign clk_div    = clk_div_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen.
// Instance a uses the default parameters (OVS=16, N=325).
// Instance b uses OVS=4 for the small-divisor scenarios.
// Edge e means the e-th rising edge with reset low and enable high.
// Outputs are sampled 1 time unit after that edge.
module tb_baud_tick_gen;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        enable;
  logic        resync;
  logic        div_wr;
  logic [15:0] div_in;

  logic [15:0] a_div;
  logic        a_os, a_mid, a_bit, a_clk;
  logic [15:0] b_div;
  logic        b_os, b_mid, b_bit, b_clk;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  baud_tick_gen u_dut_a (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .resync    (resync),
    .div_wr    (div_wr),
    .div_in    (div_in),
    .div_active(a_div),
    .os_tick   (a_os),
    .mid_tick  (a_mid),
    .bit_tick  (a_bit),
    .clk_div   (a_clk)
  );

  baud_tick_gen #(
    .OVS(4)
  ) u_dut_b (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .resync    (resync),
    .div_wr    (div_wr),
    .div_in    (div_in),
    .div_active(b_div),
    .os_tick   (b_os),
    .mid_tick  (b_mid),
    .bit_tick  (b_bit),
    .clk_div   (b_clk)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reset, then load N=4 while disabled so that pcnt/ocnt are still 0 at edge 1.
  task automatic setup_n4();
    reset  = 1'b1;
    enable = 1'b0;
    resync = 1'b0;
    div_wr = 1'b0;
    step();
    reset  = 1'b0;
    div_wr = 1'b1;
    div_in = 16'd4;
    step();
    div_wr = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    resync = 1'b0;
    div_wr = 1'b0;
    div_in = 16'd0;
    step();
    step();
    tests++;
    if (a_div !== 16'd325) begin
      fails++;
      $display("FAIL reset_div_a got=%0d want=325", a_div);
    end
    tests++;
    if ({a_os, a_mid, a_bit, a_clk} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outs_a got=%b want=0000", {a_os, a_mid, a_bit, a_clk});
    end
    tests++;
    if (b_div !== 16'd325) begin
      fails++;
      $display("FAIL reset_div_b got=%0d want=325", b_div);
    end
    tests++;
    if ({b_os, b_mid, b_bit, b_clk} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outs_b got=%b want=0000", {b_os, b_mid, b_bit, b_clk});
    end
  endtask

  // N=325, OVS=16: two full bit periods of 5200 cycles.
  task automatic test_default();
    logic [3:0] exp_v;
    reset = 1'b0;
    for (int e = 1; e <= 10400; e++) begin
      step();
      exp_v = {(e % 325) == 0, (e % 5200) == 2600, (e % 5200) == 0, (e % 5200) >= 2600};
      tests++;
      if ({a_os, a_mid, a_bit, a_clk} !== exp_v) begin
        fails++;
        if (fails <= 20) begin
          $display("FAIL default e=%0d got=%b want=%b", e, {a_os, a_mid, a_bit, a_clk}, exp_v);
        end
      end
    end
  endtask

  task automatic test_small_div();
    logic [3:0] exp_v;
    setup_n4();
    tests++;
    if (b_div !== 16'd4) begin
      fails++;
      $display("FAIL small_div_load got=%0d want=4", b_div);
    end
    enable = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      exp_v = {(e % 4) == 0, (e % 16) == 8, (e % 16) == 0, (e % 16) >= 8};
      tests++;
      if ({b_os, b_mid, b_bit, b_clk} !== exp_v) begin
        fails++;
        $display("FAIL small_div e=%0d got=%b want=%b", e, {b_os, b_mid, b_bit, b_clk}, exp_v);
      end
    end
  endtask

  task automatic test_mid_write();
    setup_n4();
    enable = 1'b1;
    step();
    div_wr = 1'b1;
    div_in = 16'd6;
    step();
    div_wr = 1'b0;
    for (int e = 3; e <= 16; e++) begin
      step();
      tests++;
      if (b_os !== (e == 4 || e == 10 || e == 16)) begin
        fails++;
        $display("FAIL mid_write_os e=%0d got=%b", e, b_os);
      end
      tests++;
      if (b_div !== ((e >= 4) ? 16'd6 : 16'd4)) begin
        fails++;
        $display("FAIL mid_write_div e=%0d got=%0d want=%0d", e, b_div, (e >= 4) ? 6 : 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    setup_n4();
    enable = 1'b1;
    div_wr = 1'b1;
    div_in = 16'd5;
    step();
    div_in = 16'd3;
    step();
    div_wr = 1'b0;
    for (int e = 3; e <= 10; e++) begin
      step();
      tests++;
      if (b_os !== (e == 4 || e == 7 || e == 10)) begin
        fails++;
        $display("FAIL b2b_os e=%0d got=%b", e, b_os);
      end
      tests++;
      if (b_div !== ((e >= 4) ? 16'd3 : 16'd4)) begin
        fails++;
        $display("FAIL b2b_div e=%0d got=%0d want=%0d", e, b_div, (e >= 4) ? 3 : 4);
      end
    end
  endtask

  task automatic test_resync();
    logic [3:0] exp_v;
    int         r;
    setup_n4();
    enable = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      tests++;
      if (b_os !== (e == 4)) begin
        fails++;
        $display("FAIL resync_pre e=%0d got=%b", e, b_os);
      end
    end
    resync = 1'b1;
    step();
    resync = 1'b0;
    tests++;
    if ({b_os, b_mid, b_bit, b_clk} !== 4'b0000) begin
      fails++;
      $display("FAIL resync_e7 got=%b want=0000", {b_os, b_mid, b_bit, b_clk});
    end
    // New phase reference is edge 7. A write lands on the wrap at edge 19 and stays pending.
    for (int e = 8; e <= 19; e++) begin
      if (e == 19) begin
        div_wr = 1'b1;
        div_in = 16'd2;
      end
      step();
      r     = e - 7;
      exp_v = {(r % 4) == 0, (r % 16) == 8, (r % 16) == 0, (r % 16) >= 8};
      tests++;
      if ({b_os, b_mid, b_bit, b_clk} !== exp_v) begin
        fails++;
        $display("FAIL resync_post e=%0d got=%b want=%b", e, {b_os, b_mid, b_bit, b_clk}, exp_v);
      end
    end
    div_wr = 1'b0;
    tests++;
    if (b_div !== 16'd4) begin
      fails++;
      $display("FAIL resync_pending got=%0d want=4", b_div);
    end
    resync = 1'b1;
    step();
    resync = 1'b0;
    tests++;
    if ({b_os, b_mid, b_bit, b_clk} !== 4'b0000) begin
      fails++;
      $display("FAIL resync_clkdiv got=%b want=0000", {b_os, b_mid, b_bit, b_clk});
    end
    tests++;
    if (b_div !== 16'd2) begin
      fails++;
      $display("FAIL resync_apply got=%0d want=2", b_div);
    end
    for (int e = 21; e <= 24; e++) begin
      step();
      exp_v = (e == 22) ? 4'b1000 : (e == 24) ? 4'b1101 : 4'b0000;
      tests++;
      if ({b_os, b_mid, b_bit, b_clk} !== exp_v) begin
        fails++;
        $display("FAIL resync_newdiv e=%0d got=%b want=%b", e, {b_os, b_mid, b_bit, b_clk}, exp_v);
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_v;
    setup_n4();
    for (int e = 1; e <= 7; e++) begin
      enable = !(e >= 3 && e <= 5);
      step();
      exp_v = (e == 7) ? 4'b1000 : 4'b0000;
      tests++;
      if ({b_os, b_mid, b_bit, b_clk} !== exp_v) begin
        fails++;
        $display("FAIL enable_gap e=%0d got=%b want=%b", e, {b_os, b_mid, b_bit, b_clk}, exp_v);
      end
    end
    enable = 1'b1;
    for (int e = 8; e <= 11; e++) begin
      step();
      exp_v = (e == 11) ? 4'b1101 : 4'b0000;
      tests++;
      if ({b_os, b_mid, b_bit, b_clk} !== exp_v) begin
        fails++;
        $display("FAIL enable_run e=%0d got=%b want=%b", e, {b_os, b_mid, b_bit, b_clk}, exp_v);
      end
    end
    // Disabled: ticks stop, clk_div holds high; a zero divisor is applied on the next idle edge.
    enable = 1'b0;
    div_wr = 1'b1;
    div_in = 16'd0;
    step();
    div_wr = 1'b0;
    tests++;
    if ({b_os, b_mid, b_bit, b_clk} !== 4'b0001) begin
      fails++;
      $display("FAIL enable_hold got=%b want=0001", {b_os, b_mid, b_bit, b_clk});
    end
    tests++;
    if (b_div !== 16'd4) begin
      fails++;
      $display("FAIL enable_div_pending got=%0d want=4", b_div);
    end
    step();
    tests++;
    if (b_div !== 16'd0) begin
      fails++;
      $display("FAIL enable_div_zero got=%0d want=0", b_div);
    end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (b_os !== 1'b1) begin
        fails++;
        $display("FAIL div_zero_os i=%0d got=%b want=1", i, b_os);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_v;
    setup_n4();
    enable = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
    end
    tests++;
    if ({b_os, b_mid, b_bit, b_clk} !== 4'b1001) begin
      fails++;
      $display("FAIL reset_mid_pre got=%b want=1001", {b_os, b_mid, b_bit, b_clk});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if ({b_os, b_mid, b_bit, b_clk} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_outs got=%b want=0000", {b_os, b_mid, b_bit, b_clk});
    end
    tests++;
    if (b_div !== 16'd325) begin
      fails++;
      $display("FAIL reset_mid_div got=%0d want=325", b_div);
    end
    for (int e = 1; e <= 1300; e++) begin
      step();
      exp_v = {(e % 325) == 0, (e % 1300) == 650, (e % 1300) == 0, (e % 1300) >= 650};
      tests++;
      if ({b_os, b_mid, b_bit, b_clk} !== exp_v) begin
        fails++;
        if (fails <= 20) begin
          $display("FAIL reset_mid_run e=%0d got=%b want=%b", e, {b_os, b_mid, b_bit, b_clk},
                   exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_small_div();
    test_mid_write();
    test_back_to_back();
    test_resync();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Programmable baud-rate tick generator for the Bluetooth serial peripheral. It replaces the fixed-constant toggling divider with a runtime-loadable divisor and an oversampling prescaler. It produces single-cycle enable pulses (oversample, bit-centre, bit-boundary) for the UART TX/RX engines, plus a 50%-duty square wave for legacy consumers. A phase resync input lets the RX engine align bit timing to a detected start-bit edge.

## Interface
Parameters:
- CNT_W, 16: width of divisor and oversample-period counter.
- OVS, 16: oversample factor, power of two, 2..256.
- DIV_RESET, 325: divisor loaded at reset (50 MHz / (9600 × 16) ≈ 325).

Ports:
- clk_in, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: run when high; counters and clk_div hold when low.
- resync, in, 1: single-cycle phase restart request.
- div_wr, in, 1: single-cycle strobe; captures div_in into the pending register.
- div_in, in, CNT_W: new divisor N, in clk_in cycles per oversample period.
- div_active, out, CNT_W: divisor currently in use.
- os_tick, out, 1: one-cycle pulse every N cycles.
- mid_tick, out, 1: one-cycle pulse at bit centre, once every N×OVS cycles.
- bit_tick, out, 1: one-cycle pulse at bit boundary, once every N×OVS cycles.
- clk_div, out, 1: square wave with period N×OVS and 50% duty.

## Operation
- Period counter pcnt (CNT_W): counts 0..N−1. When it reaches N−1 with enable high, it wraps to 0 and os_tick is registered high for the next cycle.
- Effective divisor: div_active == 0 is treated as 1, so os_tick is continuously high while enabled.
- Oversample counter ocnt (log2(OVS) bits): increments on each period wrap and wraps OVS−1 → 0.
- bit_tick: asserted coincident with the os_tick whose wrap takes ocnt from OVS−1 to 0.
- mid_tick: asserted coincident with the os_tick whose wrap takes ocnt to OVS/2.
- clk_div: toggles in the cycle mid_tick or bit_tick is high; high from the mid point to the bit boundary.
- Divisor update:
  - div_wr sets pending_valid and stores div_in.
  - The pending value is transferred to div_active only at a period wrap, on resync, or in any cycle with enable low.
  - div_wr in the same cycle as a wrap: the old pending value (if any) is applied now, and the new value is held as pending.
  - Back-to-back div_wr before transfer: last write wins.
- resync (priority over enable and wrap):
  - pcnt and ocnt are cleared, and pending is applied.
  - All ticks are 0 in the following cycle, and clk_div is forced to 0.
- enable low: no ticks, counters hold, clk_div holds.
- Reset values: pcnt = 0, ocnt = 0, pending_valid = 0, div_active = DIV_RESET, os_tick/mid_tick/bit_tick = 0, clk_div = 0.
- Reset during operation clears everything on the same edge, with no partial pulse afterwards.

## Timing
- All outputs are registered and change only on the rising edge of clk_in.
- First edge with reset low and enable high is edge 1.
- os_tick high after edges N, 2N, 3N, …; pulse width is exactly 1 cycle.
- mid_tick first high after edge N×OVS/2; bit_tick first high after edge N×OVS; repeats every N×OVS cycles.
- clk_div rises with mid_tick and falls with bit_tick.
- After resync on edge k, the next os_tick is after edge k+N, using the new divisor if one was pending.
- A divisor change never produces a period shorter than min(old, new) or a glitch on clk_div.
- Latency from div_wr to div_active update: at most the remaining cycles of the current oversample period, plus 1.

## Test plan
- Reset default (N=325, OVS=16): os_tick period 325; mid_tick after edge 2600; bit_tick after edge 5200; clk_div period 5200, duty 2600/2600.
- Small divisor (div_wr with div_in=4, OVS=4):
  - os_tick after edges 4, 8, 12, 16.
  - mid_tick at 8; bit_tick at 16.
  - clk_div high on cycles 9–16.
- Mid-period write: with N=4, write 6 at cycle 2. Period ending at 4 is unchanged; next os_tick at 10; div_active reads 6 from cycle 5.
- resync at cycle 7 with N=4: no ticks on cycle 8; next os_tick after edge 11; clk_div = 0 from cycle 8.
- enable low for cycles 3–5 with N=4: first os_tick delayed to after edge 7. Write div_in=0 while disabled: os_tick high every cycle after re-enable.
- Reset asserted mid-bit (cycle 13, N=4, OVS=4): all outputs 0 from cycle 14; ticks restart from the new edge-1 reference with div_active=DIV_RESET.
